// File: rtl/ovc_credit_status_tracker_if.sv
// Purpose : bundles the allocator/crossbar/credit strobes and the per-OVC status for the tracker.
// Latency : n/a (wires only).
// Backpressure: none; every strobe is a single-cycle pulse and the status is always valid.
//
// Ports (per OVC i = p*V + v, N = P*V):
//   ovc_allocate_all, flit_sent_all, tail_sent_all, credit_in_all : strobes into the tracker
//   ovc_free_all, ovc_full_all, ovc_nearly_full_all, ovc_avail_all : status out of the tracker
//   credit_cnt_all [i*CW +: CW]                                    : credit counter of OVC i
//   err_flags {double_alloc, send_unalloc, underflow, overflow}    : sticky error bits
interface ovc_credit_status_tracker_if #(
    parameter int P = 5,
    parameter int V = 2,
    parameter int B = 4
);
    localparam int N  = P * V;
    localparam int CW = $clog2(B + 1);

    logic [N-1:0]    ovc_allocate_all;
    logic [N-1:0]    flit_sent_all;
    logic [N-1:0]    tail_sent_all;
    logic [N-1:0]    credit_in_all;
    logic [N-1:0]    ovc_free_all;
    logic [N-1:0]    ovc_full_all;
    logic [N-1:0]    ovc_nearly_full_all;
    logic [N-1:0]    ovc_avail_all;
    logic [N*CW-1:0] credit_cnt_all;
    logic [3:0]      err_flags;

    // Allocator / crossbar / link side: drives strobes, observes status.
    modport master (
        output ovc_allocate_all, flit_sent_all, tail_sent_all, credit_in_all,
        input  ovc_free_all, ovc_full_all, ovc_nearly_full_all, ovc_avail_all,
        input  credit_cnt_all, err_flags
    );

    // Tracker side.
    modport slave (
        input  ovc_allocate_all, flit_sent_all, tail_sent_all, credit_in_all,
        output ovc_free_all, ovc_full_all, ovc_nearly_full_all, ovc_avail_all,
        output credit_cnt_all, err_flags
    );
endinterface

// File: rtl/ovc_credit_status_tracker.sv
// Purpose : per-output-VC allocated flag and saturating credit counter, with status decodes.
// Latency : a strobe in cycle n shows in the status outputs from cycle n+1 (outputs decode registers only).
// Backpressure: none; strobes are always accepted, illegal combinations set sticky error flags.
//
// Ports:
//   clk   : router clock, rising edge
//   reset : asynchronous, active-low; clears flags, loads counters with B, clears errors
//   ovc   : slave modport of ovc_credit_status_tracker_if (strobes in, status out)
module ovc_credit_status_tracker #(
    parameter int P = 5,
    parameter int V = 2,
    parameter int B = 4
) (
    input logic                       clk,
    input logic                       reset,
    ovc_credit_status_tracker_if.slave ovc
);
    localparam int N  = P * V;
    localparam int CW = $clog2(B + 1);
    // Counter ceiling in counter width; CW is sized so B always fits without aliasing.
    localparam logic [CW-1:0] B_CNT = CW'(B);

    localparam int E_DOUBLE_ALLOC = 3;
    localparam int E_SEND_UNALLOC = 2;
    localparam int E_UNDERFLOW    = 1;
    localparam int E_OVERFLOW     = 0;

    logic [N-1:0]          alloc_q, alloc_d;
    logic [N-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [3:0]            err_q, err_d;

    always_comb begin
        alloc_d = alloc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        for (int i = 0; i < N; i++) begin
            // A tail strobe only counts when a flit actually left.
            logic tail_i;
            tail_i = ovc.flit_sent_all[i] & ovc.tail_sent_all[i];

            // Set beats clear: a tail and a new grant in the same cycle hand the VC over.
            if (ovc.ovc_allocate_all[i])
                alloc_d[i] = 1'b1;
            else if (tail_i)
                alloc_d[i] = 1'b0;

            if (ovc.ovc_allocate_all[i] && alloc_q[i] && !tail_i)
                err_d[E_DOUBLE_ALLOC] = 1'b1;
            if (ovc.flit_sent_all[i] && !alloc_q[i] && !ovc.ovc_allocate_all[i])
                err_d[E_SEND_UNALLOC] = 1'b1;

            // Send and credit together net to zero, so they never trip the saturation checks.
            unique case ({ovc.flit_sent_all[i], ovc.credit_in_all[i]})
                2'b10: begin
                    if (cnt_q[i] == '0)
                        err_d[E_UNDERFLOW] = 1'b1;
                    else
                        cnt_d[i] = cnt_q[i] - CW'(1);
                end
                2'b01: begin
                    if (cnt_q[i] == B_CNT)
                        err_d[E_OVERFLOW] = 1'b1;
                    else
                        cnt_d[i] = cnt_q[i] + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alloc_q <= '0;
            cnt_q   <= {N{B_CNT}};
            err_q   <= '0;
        end else begin
            alloc_q <= alloc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Status is decoded from registered state only, so reset reaches it without a clock.
    always_comb begin
        ovc.ovc_free_all        = ~alloc_q;
        ovc.ovc_full_all        = '0;
        ovc.ovc_nearly_full_all = '0;
        ovc.ovc_avail_all       = '0;
        ovc.credit_cnt_all      = cnt_q;
        ovc.err_flags           = err_q;
        for (int i = 0; i < N; i++) begin
            ovc.ovc_full_all[i]        = (cnt_q[i] == '0);
            ovc.ovc_nearly_full_all[i] = (cnt_q[i] == CW'(1));
            ovc.ovc_avail_all[i]       = ~alloc_q[i] & (cnt_q[i] != '0);
        end
    end
endmodule

// File: tb/tb_ovc_credit_status_tracker.sv
module tb_ovc_credit_status_tracker;
    localparam int P  = 5;
    localparam int V  = 2;
    localparam int B  = 4;
    localparam int N  = P * V;
    localparam int CW = $clog2(B + 1);

    logic clk;
    logic rst_n;
    int   npass;
    int   ntotal;

    // Reference model: plain per-OVC integers, updated from the behavioural rules.
    bit   m_alloc [N];
    int   m_cnt   [N];
    bit   m_err   [4];

    ovc_credit_status_tracker_if #(.P(P), .V(V), .B(B)) bus ();

    ovc_credit_status_tracker #(.P(P), .V(V), .B(B)) dut (
        .clk   (clk),
        .reset (rst_n),
        .ovc   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_alloc[i] = 1'b0;
            m_cnt[i]   = B;
        end
        for (int k = 0; k < 4; k++) m_err[k] = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] a, input logic [N-1:0] s,
                              input logic [N-1:0] t, input logic [N-1:0] c);
        for (int i = 0; i < N; i++) begin
            bit tail;
            tail = s[i] && t[i];
            if (a[i] && m_alloc[i] && !tail) m_err[3] = 1'b1;
            if (s[i] && !m_alloc[i] && !a[i]) m_err[2] = 1'b1;
            if (s[i] && !c[i]) begin
                if (m_cnt[i] == 0) m_err[1] = 1'b1;
                else m_cnt[i] = m_cnt[i] - 1;
            end else if (c[i] && !s[i]) begin
                if (m_cnt[i] == B) m_err[0] = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end
            if (a[i]) m_alloc[i] = 1'b1;
            else if (tail) m_alloc[i] = 1'b0;
        end
    endtask

    function automatic logic [N-1:0] exp_free();
        for (int i = 0; i < N; i++) exp_free[i] = !m_alloc[i];
    endfunction
    function automatic logic [N-1:0] exp_full();
        for (int i = 0; i < N; i++) exp_full[i] = (m_cnt[i] == 0);
    endfunction
    function automatic logic [N-1:0] exp_nf();
        for (int i = 0; i < N; i++) exp_nf[i] = (m_cnt[i] == 1);
    endfunction
    function automatic logic [N-1:0] exp_avail();
        for (int i = 0; i < N; i++) exp_avail[i] = !m_alloc[i] && (m_cnt[i] > 0);
    endfunction
    function automatic logic [N*CW-1:0] exp_cnt();
        for (int i = 0; i < N; i++) exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);
    endfunction
    function automatic logic [3:0] exp_err();
        exp_err = {m_err[3], m_err[2], m_err[1], m_err[0]};
    endfunction

    // Called at a negedge; drives one cycle of strobes, returns at the following negedge.
    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] s,
                         input logic [N-1:0] t, input logic [N-1:0] c);
        bus.ovc_allocate_all = a;
        bus.flit_sent_all    = s;
        bus.tail_sent_all    = t;
        bus.credit_in_all    = c;
        @(posedge clk);
        model_step(a, s, t, c);
        @(negedge clk);
        bus.ovc_allocate_all = '0;
        bus.flit_sent_all    = '0;
        bus.tail_sent_all    = '0;
        bus.credit_in_all    = '0;
    endtask

    function automatic logic [N-1:0] one(input int i);
        one = '0;
        one[i] = 1'b1;
    endfunction

    task automatic apply_reset();
        bus.ovc_allocate_all = '0;
        bus.flit_sent_all    = '0;
        bus.tail_sent_all    = '0;
        bus.credit_in_all    = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [N*CW-1:0] all_b;
        for (int i = 0; i < N; i++) all_b[i*CW +: CW] = CW'(B);
        apply_reset();
        ntotal++; if (bus.ovc_avail_all !== {N{1'b1}})
            $display("FAIL reset_avail got %h exp %h", bus.ovc_avail_all, {N{1'b1}}); else npass++;
        ntotal++; if (bus.ovc_free_all !== {N{1'b1}})
            $display("FAIL reset_free got %h exp %h", bus.ovc_free_all, {N{1'b1}}); else npass++;
        ntotal++; if (bus.ovc_full_all !== '0 || bus.ovc_nearly_full_all !== '0)
            $display("FAIL reset_full got %h/%h exp 0/0", bus.ovc_full_all, bus.ovc_nearly_full_all); else npass++;
        ntotal++; if (bus.credit_cnt_all !== all_b)
            $display("FAIL reset_cnt got %h exp %h", bus.credit_cnt_all, all_b); else npass++;
        ntotal++; if (bus.err_flags !== 4'b0000)
            $display("FAIL reset_err got %b exp 0000", bus.err_flags); else npass++;
    endtask

    task automatic test_drain();
        drive(one(3), '0, '0, '0);
        ntotal++; if (bus.ovc_free_all[3] !== 1'b0 || bus.ovc_avail_all[3] !== 1'b0)
            $display("FAIL drain_alloc got free=%b avail=%b exp 0/0", bus.ovc_free_all[3], bus.ovc_avail_all[3]); else npass++;
        for (int k = 1; k <= 4; k++) begin
            logic [CW-1:0] want;
            want = CW'(B - k);
            drive('0, one(3), '0, '0);
            ntotal++; if (bus.credit_cnt_all[3*CW +: CW] !== want)
                $display("FAIL drain_cnt%0d got %0d exp %0d", k, bus.credit_cnt_all[3*CW +: CW], want); else npass++;
            ntotal++; if (bus.ovc_nearly_full_all[3] !== (want == 1) || bus.ovc_full_all[3] !== (want == 0))
                $display("FAIL drain_flags%0d got nf=%b full=%b exp %b/%b", k,
                         bus.ovc_nearly_full_all[3], bus.ovc_full_all[3], want == 1, want == 0); else npass++;
        end
        ntotal++; if (bus.ovc_avail_all[3] !== 1'b0 || bus.err_flags !== 4'b0000)
            $display("FAIL drain_end got avail=%b err=%b exp 0/0000", bus.ovc_avail_all[3], bus.err_flags); else npass++;
    endtask

    task automatic test_net_zero();
        drive('0, one(3), '0, one(3));
        ntotal++; if (bus.credit_cnt_all[3*CW +: CW] !== CW'(0) || bus.err_flags[1] !== 1'b0)
            $display("FAIL netzero got cnt=%0d uf=%b exp 0/0", bus.credit_cnt_all[3*CW +: CW], bus.err_flags[1]); else npass++;
        drive('0, one(3), '0, '0);
        ntotal++; if (bus.credit_cnt_all[3*CW +: CW] !== CW'(0) || bus.err_flags !== 4'b0010)
            $display("FAIL underflow got cnt=%0d err=%b exp 0/0010", bus.credit_cnt_all[3*CW +: CW], bus.err_flags); else npass++;
    endtask

    task automatic test_alloc_tail();
        drive(one(5), '0, '0, '0);
        drive(one(5), one(5), one(5), '0);
        ntotal++; if (bus.ovc_free_all[5] !== 1'b0 || bus.err_flags[3] !== 1'b0)
            $display("FAIL handover got free=%b da=%b exp 0/0", bus.ovc_free_all[5], bus.err_flags[3]); else npass++;
        drive('0, '0, one(5), '0);
        ntotal++; if (bus.ovc_free_all[5] !== 1'b0)
            $display("FAIL lone_tail got free=%b exp 0", bus.ovc_free_all[5]); else npass++;
        drive('0, one(5), one(5), '0);
        ntotal++; if (bus.ovc_free_all[5] !== 1'b1 || bus.credit_cnt_all[5*CW +: CW] !== CW'(B - 2))
            $display("FAIL tail_free got free=%b cnt=%0d exp 1/%0d", bus.ovc_free_all[5],
                     bus.credit_cnt_all[5*CW +: CW], B - 2); else npass++;
    endtask

    task automatic test_overflow_double();
        drive('0, '0, '0, one(0));
        ntotal++; if (bus.err_flags[0] !== 1'b1 || bus.credit_cnt_all[0 +: CW] !== CW'(B))
            $display("FAIL overflow got of=%b cnt=%0d exp 1/%0d", bus.err_flags[0], bus.credit_cnt_all[0 +: CW], B); else npass++;
        drive(one(0), '0, '0, '0);
        ntotal++; if (bus.err_flags[3] !== 1'b0)
            $display("FAIL first_alloc got da=%b exp 0", bus.err_flags[3]); else npass++;
        drive(one(0), '0, '0, '0);
        ntotal++; if (bus.err_flags[3] !== 1'b1)
            $display("FAIL double_alloc got da=%b exp 1", bus.err_flags[3]); else npass++;
        ntotal++; if (bus.err_flags !== exp_err())
            $display("FAIL err_model got %b exp %b", bus.err_flags, exp_err()); else npass++;
    endtask

    task automatic test_send_unalloc();
        drive('0, one(7), '0, '0);
        ntotal++; if (bus.err_flags[2] !== 1'b1 || bus.credit_cnt_all[7*CW +: CW] !== CW'(B - 1))
            $display("FAIL send_unalloc got su=%b cnt=%0d exp 1/%0d", bus.err_flags[2],
                     bus.credit_cnt_all[7*CW +: CW], B - 1); else npass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            logic [N-1:0] a, s, t, c;
            for (int i = 0; i < N; i++) begin
                a[i] = ($urandom_range(0, 7) == 0);
                s[i] = ($urandom_range(0, 2) == 0);
                t[i] = ($urandom_range(0, 3) == 0);
                c[i] = ($urandom_range(0, 2) == 0);
            end
            drive(a, s, t, c);
            ntotal++; if (bus.credit_cnt_all !== exp_cnt())
                $display("FAIL rnd_cnt[%0d] got %h exp %h", n, bus.credit_cnt_all, exp_cnt()); else npass++;
            ntotal++; if (bus.ovc_free_all !== exp_free() || bus.ovc_avail_all !== exp_avail())
                $display("FAIL rnd_free[%0d] got %h/%h exp %h/%h", n, bus.ovc_free_all, bus.ovc_avail_all,
                         exp_free(), exp_avail()); else npass++;
            ntotal++; if (bus.ovc_full_all !== exp_full() || bus.ovc_nearly_full_all !== exp_nf())
                $display("FAIL rnd_full[%0d] got %h/%h exp %h/%h", n, bus.ovc_full_all, bus.ovc_nearly_full_all,
                         exp_full(), exp_nf()); else npass++;
            ntotal++; if (bus.err_flags !== exp_err())
                $display("FAIL rnd_err[%0d] got %b exp %b", n, bus.err_flags, exp_err()); else npass++;
        end
    endtask

    task automatic test_async_reset();
        logic [N*CW-1:0] all_b;
        for (int i = 0; i < N; i++) all_b[i*CW +: CW] = CW'(B);
        apply_reset();
        drive(one(2), '0, '0, '0);
        repeat (3) drive('0, one(2), '0, '0);
        drive('0, one(4), '0, '0);
        ntotal++; if (bus.credit_cnt_all[2*CW +: CW] !== CW'(1) || bus.ovc_free_all[2] !== 1'b0 || bus.err_flags !== 4'b0100)
            $display("FAIL pre_reset got cnt=%0d free=%b err=%b exp 1/0/0100", bus.credit_cnt_all[2*CW +: CW],
                     bus.ovc_free_all[2], bus.err_flags); else npass++;
        #2 rst_n = 1'b0;
        #1;
        ntotal++; if (bus.credit_cnt_all !== all_b || bus.ovc_free_all !== {N{1'b1}})
            $display("FAIL async_cnt got %h/%h exp %h/%h", bus.credit_cnt_all, bus.ovc_free_all, all_b, {N{1'b1}}); else npass++;
        ntotal++; if (bus.err_flags !== 4'b0000 || bus.ovc_avail_all !== {N{1'b1}} || bus.ovc_nearly_full_all !== '0)
            $display("FAIL async_status got err=%b avail=%h nf=%h exp 0000/%h/0", bus.err_flags,
                     bus.ovc_avail_all, bus.ovc_nearly_full_all, {N{1'b1}}); else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        rst_n  = 1'b1;
        bus.ovc_allocate_all = '0;
        bus.flit_sent_all    = '0;
        bus.tail_sent_all    = '0;
        bus.credit_in_all    = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_drain();
        test_net_zero();
        test_alloc_tail();
        test_overflow_double();
        test_send_unalloc();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
